// File: rtl/apb_csr_pkg.sv
// apb_csr_pkg: shared types, register offsets and byte-lane merge for the APB CSR completer.
package apb_csr_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [15:0] ADDR_ID       = 16'h00;
  localparam logic [15:0] ADDR_CTRL     = 16'h04;
  localparam logic [15:0] ADDR_STATUS   = 16'h08;
  localparam logic [15:0] ADDR_IRQ_STAT = 16'h0C;
  localparam logic [15:0] ADDR_IRQ_EN   = 16'h10;
  localparam logic [15:0] ADDR_SCRATCH  = 16'h14;
  localparam logic [15:0] ADDR_TICK     = 16'h18;
  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return m;
  endfunction
endpackage

// File: rtl/apb_wait_gen.sv
// apb_wait_gen: APB setup/access sequencing with a programmable number of wait states.
module apb_wait_gen
  import apb_csr_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic psel,
  input  logic penable,
  output logic ready
);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // A setup phase seen while already in ACCESS restarts the transfer.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b0;
    if (psel && !penable) begin
      state_nx = ACCESS;
      cnt_nx   = 4'(WAIT_STATES);
    end else if (state == ACCESS) begin
      if (!psel) state_nx = IDLE;
      else if (cnt != '0) cnt_nx = cnt - 4'd1;
      else begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
    end
  end
endmodule

// File: rtl/apb_csr_completer.sv
// apb_csr_completer: APB completer for the GNSS peripheral control/status register bank.
// TICK_RST only exists so the tick wrap can be reached quickly; keep it 0 in real instances.
module apb_csr_completer
  import apb_csr_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h474E_5301,
  parameter int          IRQ_W       = 8,
  parameter logic [31:0] TICK_RST    = 32'h0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [15:0]      apb_paddr,
  input  logic             apb_pwrite,
  input  logic             apb_psel,
  input  logic             apb_penable,
  input  logic [3:0]       apb_pstrb,
  input  logic [31:0]      apb_pwdata,
  output logic [31:0]      apb_prdata,
  output logic             apb_pready,
  output logic             apb_pslverr,
  output logic [31:0]      ctrl_o,
  input  logic [31:0]      status_i,
  input  logic [IRQ_W-1:0] irq_set_i,
  input  logic             tick_i,
  output logic             irq_o
);
  logic ready, err, wr;
  logic [31:0] ctrl, scratch, tick_cnt, rdata;
  logic [IRQ_W-1:0] irq_stat, irq_en, clr;
  apb_wait_gen #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .psel    (apb_psel),
    .penable (apb_penable),
    .ready   (ready)
  );
  assign err = apb_paddr > ADDR_TICK || apb_paddr[1:0] != 2'b00 ||
               (apb_pwrite && (apb_paddr == ADDR_ID || apb_paddr == ADDR_STATUS || apb_paddr == ADDR_TICK));
  assign wr  = ready && apb_pwrite && !err;
  assign clr = (wr && apb_paddr == ADDR_IRQ_STAT) ? IRQ_W'(apb_pwdata & merge('0, '1, apb_pstrb)) : '0;
  always_comb begin
    rdata = '0;
    case (apb_paddr)
      ADDR_ID:       rdata = ID_VALUE;
      ADDR_CTRL:     rdata = ctrl;
      ADDR_STATUS:   rdata = status_i;
      ADDR_IRQ_STAT: rdata = 32'(irq_stat);
      ADDR_IRQ_EN:   rdata = 32'(irq_en);
      ADDR_SCRATCH:  rdata = scratch;
      ADDR_TICK:     rdata = tick_cnt;
      default:       rdata = '0;
    endcase
  end
  assign apb_pready  = ready;
  assign apb_pslverr = ready && err;
  assign apb_prdata  = (ready && !err && !apb_pwrite) ? rdata : '0;
  assign ctrl_o      = ctrl;
  // Pending set pulses are OR-ed in after the clear so a simultaneous set wins.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      scratch  <= '0;
      irq_stat <= '0;
      irq_en   <= '0;
      tick_cnt <= TICK_RST;
      irq_o    <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt + 32'(tick_i);
      irq_stat <= (irq_stat & ~clr) | irq_set_i;
      irq_o    <= |(irq_stat & irq_en);
      if (wr && apb_paddr == ADDR_CTRL) ctrl <= merge(ctrl, apb_pwdata, apb_pstrb);
      if (wr && apb_paddr == ADDR_SCRATCH) scratch <= merge(scratch, apb_pwdata, apb_pstrb);
      if (wr && apb_paddr == ADDR_IRQ_EN) irq_en <= IRQ_W'(merge(32'(irq_en), apb_pwdata, apb_pstrb));
    end
  end
endmodule

// File: tb/tb_apb_csr_completer.sv
// tb_apb_csr_completer: randomized and directed checks of the APB CSR completer against a register-map model.
module tb_apb_csr_completer;
  localparam logic [31:0] ID = 32'h474E_5301;
  logic sys_clk = 0, rst_n = 0;
  logic [15:0] paddr = 0;
  logic pwrite = 0, psel_a = 0, psel_b = 0, penable = 0, tick_a = 0, tick_b = 0;
  logic [3:0] pstrb = 0;
  logic [31:0] pwdata = 0, status = 0;
  logic [7:0] irq_set_a = 0, irq_set_b = 0;
  logic [31:0] prdata_a, prdata_b, ctrl_a, ctrl_b;
  logic pready_a, pready_b, pslverr_a, pslverr_b, irq_a, irq_b;
  int tests = 0, fails = 0;
  logic [31:0] m_ctrl, m_scr, m_tick;
  logic [7:0] m_stat, m_en;
  logic m_irq;
  bit rnd = 0, sel = 0;
  logic s_ready, s_err, exp_err;
  logic [31:0] s_rd, exp_rd;
  bit t_ready, t_early, t_err, t_eerr;
  logic [31:0] t_rd, t_erd;
  int t_acc;

  always #5 sys_clk = ~sys_clk;

  apb_csr_completer #(.WAIT_STATES(1)) u_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .apb_paddr(paddr), .apb_pwrite(pwrite), .apb_psel(psel_a),
    .apb_penable(penable), .apb_pstrb(pstrb), .apb_pwdata(pwdata), .apb_prdata(prdata_a),
    .apb_pready(pready_a), .apb_pslverr(pslverr_a), .ctrl_o(ctrl_a), .status_i(status),
    .irq_set_i(irq_set_a), .tick_i(tick_a), .irq_o(irq_a));
  apb_csr_completer #(.WAIT_STATES(3), .TICK_RST(32'hFFFF_FFFE)) u_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .apb_paddr(paddr), .apb_pwrite(pwrite), .apb_psel(psel_b),
    .apb_penable(penable), .apb_pstrb(pstrb), .apb_pwdata(pwdata), .apb_prdata(prdata_b),
    .apb_pready(pready_b), .apb_pslverr(pslverr_b), .ctrl_o(ctrl_b), .status_i(status),
    .irq_set_i(irq_set_b), .tick_i(tick_b), .irq_o(irq_b));

  function automatic logic [31:0] lanes(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  function automatic bit bad(input logic [15:0] a, input logic w);
    return a > 16'h18 || a[1:0] != 2'b00 || (w && (a == 16'h00 || a == 16'h08 || a == 16'h18));
  endfunction
  function automatic logic [31:0] mdl_rd(input logic [15:0] a);
    if (bad(a, 1'b0)) return 32'h0;
    case (a)
      16'h00:  return ID;
      16'h04:  return m_ctrl;
      16'h08:  return status;
      16'h0C:  return {24'h0, m_stat};
      16'h10:  return {24'h0, m_en};
      16'h14:  return m_scr;
      default: return m_tick;
    endcase
  endfunction
  task automatic m_reset();
    m_ctrl = 0; m_scr = 0; m_tick = 0; m_stat = 0; m_en = 0; m_irq = 0;
  endtask

  // One clock: sample at the falling edge, advance the model of DUT a, return 1 after the rising edge.
  task automatic step();
    logic [31:0] mk;
    logic [7:0] clr;
    bit wr_ok, nirq;
    if (rnd) begin
      irq_set_a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      tick_a = 1'($urandom_range(0, 1));
      status = $urandom;
    end
    @(negedge sys_clk);
    s_ready = sel ? pready_b : pready_a;
    s_err = sel ? pslverr_b : pslverr_a;
    s_rd = sel ? prdata_b : prdata_a;
    if (pready_a) begin
      exp_rd = mdl_rd(paddr);
      exp_err = bad(paddr, pwrite);
    end
    wr_ok = pready_a && pwrite && !bad(paddr, pwrite);
    mk = lanes(pstrb);
    nirq = |(m_stat & m_en);
    clr = (wr_ok && paddr == 16'h0C) ? pwdata[7:0] & mk[7:0] : 8'h0;
    m_stat = (m_stat & ~clr) | irq_set_a;
    if (wr_ok && paddr == 16'h04) m_ctrl = (m_ctrl & ~mk) | (pwdata & mk);
    if (wr_ok && paddr == 16'h14) m_scr = (m_scr & ~mk) | (pwdata & mk);
    if (wr_ok && paddr == 16'h10) m_en = (m_en & ~mk[7:0]) | (pwdata[7:0] & mk[7:0]);
    m_tick = m_tick + 32'(tick_a);
    m_irq = nirq;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic xfer(input bit b, input logic [15:0] a, input bit w, input logic [31:0] d, input logic [3:0] s,
                      input int abort_at, input int resetup_at, input logic [7:0] set_acc);
    int i = 0, guard = 0;
    bit done = 0;
    t_ready = 0; t_rd = 0; t_err = 0;
    sel = b; paddr = a; pwrite = w; pwdata = d; pstrb = s; psel_a = !b; psel_b = b; penable = 0;
    step();
    t_early = s_ready;
    penable = 1;
    while (!done && guard < 40) begin
      guard++;
      if (i + 1 == abort_at) begin
        psel_a = 0; psel_b = 0; penable = 0;
        step();
        t_early |= s_ready;
        done = 1;
      end else if (i + 1 == resetup_at) begin
        penable = 0;
        step();
        t_early |= s_ready;
        penable = 1; i = 0; resetup_at = 0;
      end else begin
        if (!rnd) irq_set_a = set_acc;
        step();
        i++;
        if (s_ready) begin
          done = 1; t_ready = 1; t_rd = s_rd; t_err = s_err; t_erd = exp_rd; t_eerr = exp_err;
        end else if (s_err || s_rd != 0) t_early = 1;
      end
    end
    t_acc = i;
    psel_a = 0; psel_b = 0; penable = 0;
    if (!rnd) irq_set_a = 0;
  endtask

  task automatic test_reset();
    tests++; if ({pready_a, pslverr_a, irq_a, pready_b, pslverr_b, irq_b} !== 6'b0) begin fails++; $display("FAIL reset_flags got=%b exp=000000", {pready_a, pslverr_a, irq_a, pready_b, pslverr_b, irq_b}); end
    tests++; if (prdata_a !== 0 || ctrl_a !== 0 || ctrl_b !== 0) begin fails++; $display("FAIL reset_data got=%h/%h/%h exp=0", prdata_a, ctrl_a, ctrl_b); end
    xfer(0, 16'h00, 0, 0, 0, 0, 0, 0);
    tests++; if (t_acc !== 2 || !t_ready || t_early) begin fails++; $display("FAIL id_latency got=%0d ready=%0b early=%0b exp=2 1 0", t_acc, t_ready, t_early); end
    tests++; if (t_rd !== ID || t_err !== 0) begin fails++; $display("FAIL id_read got=%h err=%0b exp=%h err=0", t_rd, t_err, ID); end
  endtask

  task automatic test_ctrl_strobe();
    xfer(0, 16'h04, 1, 32'hA5A5_A5A5, 4'b0101, 0, 0, 0);
    tests++; if (ctrl_a !== 32'h00A5_00A5 || t_err !== 0) begin fails++; $display("FAIL ctrl_strobe got=%h err=%0b exp=00a500a5", ctrl_a, t_err); end
    xfer(0, 16'h04, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 32'h00A5_00A5) begin fails++; $display("FAIL ctrl_readback got=%h exp=00a500a5", t_rd); end
  endtask

  task automatic test_errors();
    logic [15:0] addrs[5] = '{16'h08, 16'h00, 16'h18, 16'h05, 16'h20};
    bit wrs[5] = '{1, 1, 1, 1, 0};
    for (int k = 0; k < 5; k++) begin
      xfer(0, addrs[k], wrs[k], 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      tests++; if (!t_ready || t_err !== 1 || t_rd !== 0) begin fails++; $display("FAIL err_%h ready=%0b got err=%0b rd=%h exp err=1 rd=0", addrs[k], t_ready, t_err, t_rd); end
    end
    tests++; if (ctrl_a !== 32'h00A5_00A5) begin fails++; $display("FAIL err_no_state got=%h exp=00a500a5", ctrl_a); end
    xfer(0, 16'h18, 0, 0, 0, 0, 0, 0);
    tests++; if (t_err !== 0 || t_rd !== 0) begin fails++; $display("FAIL tick_legal got err=%0b rd=%h exp err=0 rd=0", t_err, t_rd); end
  endtask

  task automatic test_irq();
    xfer(0, 16'h10, 1, 32'h0000_0004, 4'hF, 0, 0, 0);
    irq_set_a = 8'h05;
    step();
    irq_set_a = 0;
    tests++; if (irq_a !== 0) begin fails++; $display("FAIL irq_early got=%0b exp=0", irq_a); end
    step();
    tests++; if (irq_a !== 1 || m_irq !== 1) begin fails++; $display("FAIL irq_assert got=%0b exp=1", irq_a); end
    xfer(0, 16'h0C, 1, 32'h0000_0004, 4'hF, 0, 0, 8'h04);
    xfer(0, 16'h0C, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 32'h05) begin fails++; $display("FAIL irq_set_wins got=%h exp=00000005", t_rd); end
    xfer(0, 16'h0C, 1, 32'h0000_0004, 4'hF, 0, 0, 0);
    xfer(0, 16'h0C, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 32'h01) begin fails++; $display("FAIL irq_w1c got=%h exp=00000001", t_rd); end
    tests++; if (irq_a !== 0) begin fails++; $display("FAIL irq_deassert got=%0b exp=0", irq_a); end
    xfer(0, 16'h0C, 1, 32'h0000_0001, 4'hE, 0, 0, 0);
    xfer(0, 16'h0C, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 32'h01) begin fails++; $display("FAIL irq_w1c_strobe got=%h exp=00000001", t_rd); end
  endtask

  task automatic test_tick_wrap();
    tick_b = 1;
    repeat (3) step();
    tick_b = 0;
    xfer(1, 16'h18, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 32'h1 || t_acc !== 4) begin fails++; $display("FAIL tick_wrap got=%h lat=%0d exp=00000001 lat=4", t_rd, t_acc); end
  endtask

  task automatic test_abort();
    xfer(1, 16'h14, 1, 32'hFFFF_FFFF, 4'hF, 3, 0, 0);
    tests++; if (t_ready || t_early) begin fails++; $display("FAIL abort_ready got=%0b/%0b exp=0/0", t_ready, t_early); end
    xfer(1, 16'h14, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 0 || t_acc !== 4 || t_early) begin fails++; $display("FAIL abort_nocommit got=%h lat=%0d exp=0 lat=4", t_rd, t_acc); end
    xfer(1, 16'h14, 1, 32'h1234_5678, 4'hF, 0, 3, 0);
    tests++; if (t_acc !== 4 || !t_ready || t_early) begin fails++; $display("FAIL resetup_lat got=%0d exp=4", t_acc); end
    xfer(1, 16'h14, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 32'h1234_5678) begin fails++; $display("FAIL resetup_data got=%h exp=12345678", t_rd); end
    xfer(0, 16'h04, 1, 32'hFFFF_FFFF, 4'hF, 2, 0, 0);
    tests++; if (ctrl_a !== m_ctrl || ctrl_a !== 32'h00A5_00A5) begin fails++; $display("FAIL abort_a got=%h exp=00a500a5", ctrl_a); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit w;
    rnd = 1;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        7: a = 16'h1C;
        8: a = 16'($urandom_range(16'h19, 16'hFFFF));
        9: a = 16'($urandom_range(0, 6) * 4 + $urandom_range(1, 3));
        default: a = 16'($urandom_range(0, 6) * 4);
      endcase
      w = 1'($urandom_range(0, 1));
      xfer(0, a, w, $urandom, 4'($urandom), 0, 0, 0);
      tests++; if (!t_ready || t_acc !== 2 || t_err !== t_eerr) begin fails++; $display("FAIL rnd_xfer a=%h w=%0b got lat=%0d err=%0b exp lat=2 err=%0b", a, w, t_acc, t_err, t_eerr); end
      if (!w) begin
        tests++; if (t_rd !== t_erd) begin fails++; $display("FAIL rnd_read a=%h got=%h exp=%h", a, t_rd, t_erd); end
      end
      tests++; if (ctrl_a !== m_ctrl || irq_a !== m_irq) begin fails++; $display("FAIL rnd_state got=%h/%0b exp=%h/%0b", ctrl_a, irq_a, m_ctrl, m_irq); end
    end
    rnd = 0; irq_set_a = 0; tick_a = 0;
  endtask

  task automatic test_reset_mid();
    xfer(0, 16'h10, 1, 32'hFF, 4'hF, 0, 0, 0);
    irq_set_a = 8'h01;
    step();
    irq_set_a = 0;
    step();
    sel = 0; paddr = 16'h04; pwrite = 1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; psel_a = 1; penable = 0;
    step();
    penable = 1;
    step();
    tests++; if (pready_a !== 1 || irq_a !== 1) begin fails++; $display("FAIL pre_reset got ready=%0b irq=%0b exp 1 1", pready_a, irq_a); end
    #2 rst_n = 0;
    #1;
    tests++; if ({pready_a, pslverr_a, irq_a} !== 3'b0 || prdata_a !== 0 || ctrl_a !== 0) begin fails++; $display("FAIL mid_reset got=%b %h %h exp=000 0 0", {pready_a, pslverr_a, irq_a}, prdata_a, ctrl_a); end
    psel_a = 0; penable = 0;
    @(posedge sys_clk);
    #1 rst_n = 1;
    m_reset();
    xfer(0, 16'h04, 0, 0, 0, 0, 0, 0);
    tests++; if (t_rd !== 0 || t_acc !== 2) begin fails++; $display("FAIL post_reset got=%h lat=%0d exp=0 lat=2", t_rd, t_acc); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1;
    test_reset();
    test_ctrl_strobe();
    test_errors();
    test_irq();
    test_tick_wrap();
    test_abort();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apb_csr_completer.md
Name: apb_csr_completer

Overview:
APB completer for the far end of the MCU-to-peripheral path. It decodes APB transfers into a small control/status register bank for a GNSS peripheral.
- Features: configurable wait states, byte-strobed writes, write-1-to-clear interrupt status, a free-running tick counter and PSLVERR on illegal accesses.
- Placement: one instance per peripheral, on the APB segment driven by the host bridge.

Parameters:
- WAIT_STATES, 1: access-phase cycles with PREADY low before completion (0..15).
- ID_VALUE, 32'h474E_5301: constant returned by the ID register.
- IRQ_W, 8: number of interrupt sources (1..32).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- apb_paddr  in  16  APB byte address
- apb_pwrite  in  1  1 = write, 0 = read
- apb_psel  in  1  completer select
- apb_penable  in  1  access phase
- apb_pstrb  in  4  write byte strobes
- apb_pwdata  in  32  write data
- apb_prdata  out  32  read data
- apb_pready  out  1  transfer complete
- apb_pslverr  out  1  transfer error, valid only while apb_pready=1
- ctrl_o  out  32  CTRL register contents
- status_i  in  32  live peripheral status
- irq_set_i  in  IRQ_W  one-cycle interrupt set pulses
- tick_i  in  1  count-enable strobe
- irq_o  out  1  registered interrupt request

Behaviour:
- Reset values: state IDLE; wait counter 0; CTRL, SCRATCH, IRQ_STAT, IRQ_EN and TICK_CNT all 0; ctrl_o 0; irq_o 0; apb_pready 0; apb_pslverr 0; apb_prdata 0.
- Register map (paddr[15:0], word aligned):
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x04 CTRL: RW, 32 bits.
  - 0x08 STATUS: RO, returns status_i.
  - 0x0C IRQ_STAT: W1C, IRQ_W bits.
  - 0x10 IRQ_EN: RW, IRQ_W bits.
  - 0x14 SCRATCH: RW, 32 bits.
  - 0x18 TICK_CNT: RO, 32 bits.
  - Bits above IRQ_W read 0 and ignore writes.
- Errors: all of the following complete normally with PREADY and set PSLVERR=1 on the completing cycle:
  - any address >0x18;
  - paddr[1:0]!=0;
  - a write to a RO register.
  - An errored transfer modifies no state and returns prdata=0.
- FSM states: IDLE, ACCESS.
  - IDLE: psel=1 & penable=0 (setup phase) -> load wait counter with WAIT_STATES, go to ACCESS.
  - ACCESS, psel=1 & penable=1: if counter!=0, decrement and hold pready=0.
  - ACCESS, counter==0: pready=1 combinationally in that cycle; commit the write or drive read data; return to IDLE.
  - ACCESS with psel=0 (abort): return to IDLE with no commit.
  - psel=1 & penable=0 while in ACCESS (protocol violation): treat as a new setup and reload the counter.
- Latency: WAIT_STATES=0 gives zero-wait (2-cycle transfer). Each wait state adds 1 cycle.
- pready, pslverr and prdata are 0 in every cycle except the completing cycle.
- Read data is a combinational mux sampled at completion. STATUS reflects status_i on that cycle.
- Writes to RW registers apply per byte lane. Lane b updates only if pstrb[b]=1, taking effect the cycle after completion.
- W1C on IRQ_STAT: clears bits whose pwdata bit=1 within strobed lanes.
  - IRQ_STAT bit i is set by irq_set_i[i].
  - A set and a clear on the same bit in the same cycle: set wins.
- TICK_CNT increments by 1 when tick_i=1 and wraps 0xFFFF_FFFF -> 0 with no flag.
- irq_o <= |(IRQ_STAT & IRQ_EN), one cycle after the state change.
- ctrl_o is driven directly from CTRL.
- Reset asserted mid-transfer: everything returns to reset values immediately, and no partial write is committed.

Decomposition:
- Package apb_csr_pkg holds:
  - state enum (IDLE, ACCESS);
  - register offset localparams (ADDR_ID ... ADDR_TICK);
  - a strobe-merge function, merge(old, new, strb).
- One sub-module, apb_wait_gen: wait counter plus pready generation. It is reusable by other completers.
- Register bank, decode and read mux stay in the top module.

Test Plan:
- Reset, then read 0x00 with WAIT_STATES=1 -> PREADY high on the 2nd access cycle, prdata=0x474E5301, pslverr=0.
- Write 0x04 data 0xA5A5A5A5 with pstrb=4'b0101, CTRL previously 0 -> ctrl_o=0x00A500A5; readback matches.
- Write 0x08 (RO) and read 0x20 -> both complete with pslverr=1; state unchanged; prdata=0.
- Pulse irq_set_i=8'h05 with IRQ_EN=0x04 -> irq_o=1 next cycle.
  - Then W1C 0x0C with 0x04, same cycle as irq_set_i[2]=1 -> bit stays set.
  - Retry without the pulse -> IRQ_STAT=0x01, irq_o=0.
- Preload TICK_CNT to 0xFFFFFFFE via a force-free path (run 2^32-2 ticks in a fast model, or a test-only parameter), then 3 ticks -> reads 0x00000001.
- Drop psel mid-wait with WAIT_STATES=3 on a SCRATCH write -> no commit, FSM IDLE.
  - Then assert rst_n=0 during a subsequent access -> all outputs 0 immediately.
